// File: rtl/fetch.sv
// Instruction fetch stage: owns the PC, issues in-order requests on a
// req/gnt + rvalid instruction-memory port, buffers returned words and
// presents them to decode. Redirects squash buffered words and drop every
// response that was already in flight when the redirect arrived.

package fetch_pkg;
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;
endpackage

// Handshake semantics:
//   imem side : a request transfers in any cycle where imem_req_o & imem_gnt_i
//               are both high; imem_req_o may drop without a grant. Each
//               imem_rvalid_i beat answers the oldest ungranted-response request.
//   decode side: an entry transfers in any cycle where if_id_o.valid & !stall_i;
//               while stalled the same head entry is presented again.
module fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output if_id_t      if_id_o
);

  // Counter width holds 0..FIFO_DEPTH; pointer width indexes 0..FIFO_DEPTH-1.
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW:0]   DEPTH_C  = (CW + 1)'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

  // Pointer increment that also wraps for non-power-of-two depths.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;     // requests granted, response pending
  logic [CW-1:0] disc_cnt_q, disc_cnt_d;   // pending responses to throw away
  logic [CW-1:0] buf_cnt_q, buf_cnt_d;     // words held for decode

  // Tag FIFO: PC of every in-flight request, in request order.
  logic [31:0]   tag_pc_q [FIFO_DEPTH];
  logic [PW-1:0] tag_wr_q, tag_wr_d;
  logic [PW-1:0] tag_rd_q, tag_rd_d;

  // Instruction buffer: {pc, instr} words ready for decode.
  logic [31:0]   buf_pc_q    [FIFO_DEPTH];
  logic [31:0]   buf_instr_q [FIFO_DEPTH];
  logic [PW-1:0] buf_wr_q, buf_wr_d;
  logic [PW-1:0] buf_rd_q, buf_rd_d;

  // ---------------------------------------------------------------------
  // Event decode
  // ---------------------------------------------------------------------
  logic [CW:0] credits_used;
  logic        has_credit;
  logic        req;
  logic        grant;
  logic        resp;
  logic        resp_drop;
  logic        buf_push;
  logic        out_valid;
  logic        buf_pop;

  // Credits cover both in-flight and buffered words, so a returning response
  // always finds a free buffer slot.
  always_comb begin
    credits_used = {1'b0, out_cnt_q} + {1'b0, buf_cnt_q};
    has_credit   = credits_used < DEPTH_C;
    req          = rst_i & ~redirect_i & has_credit;
    grant        = req & imem_gnt_i;
    // An rvalid with nothing outstanding is ignored (flagged below).
    resp         = imem_rvalid_i & (out_cnt_q != '0);
    // Stale words: either owed from an earlier redirect or arriving during one.
    resp_drop    = resp & ((disc_cnt_q != '0) | redirect_i);
    buf_push     = resp & ~resp_drop;
    out_valid    = rst_i & ~redirect_i & (buf_cnt_q != '0);
    buf_pop      = out_valid & ~stall_i;
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  // PC: redirect target wins; otherwise advance only on an accepted request.
  always_comb begin
    pc_d = pc_q;
    if (redirect_i) begin
      pc_d = {redirect_pc_i[31:2], 2'b00};
    end else if (grant) begin
      pc_d = pc_q + 32'd4;
    end
  end

  // In-flight and discard counters.
  always_comb begin
    out_cnt_d  = out_cnt_q + CW'(grant) - CW'(resp);
    disc_cnt_d = disc_cnt_q;
    if (redirect_i) begin
      // Everything still outstanding after this cycle's response is stale.
      disc_cnt_d = out_cnt_q - CW'(resp);
    end else if (resp && (disc_cnt_q != '0)) begin
      disc_cnt_d = disc_cnt_q - 1'b1;
    end
  end

  // Tag FIFO pointers follow grants and responses, even across redirects.
  always_comb begin
    tag_wr_d = grant ? ptr_inc(tag_wr_q) : tag_wr_q;
    tag_rd_d = resp  ? ptr_inc(tag_rd_q) : tag_rd_q;
  end

  // Instruction buffer bookkeeping; a redirect empties it outright.
  always_comb begin
    buf_cnt_d = buf_cnt_q;
    buf_wr_d  = buf_wr_q;
    buf_rd_d  = buf_rd_q;
    if (redirect_i) begin
      buf_cnt_d = '0;
      buf_wr_d  = '0;
      buf_rd_d  = '0;
    end else begin
      if (buf_push) buf_wr_d = ptr_inc(buf_wr_q);
      if (buf_pop)  buf_rd_d = ptr_inc(buf_rd_q);
      case ({buf_push, buf_pop})
        2'b10:   buf_cnt_d = buf_cnt_q + 1'b1;
        2'b01:   buf_cnt_d = buf_cnt_q - 1'b1;
        default: buf_cnt_d = buf_cnt_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  // Control state with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      pc_q       <= RESET_PC;
      out_cnt_q  <= '0;
      disc_cnt_q <= '0;
      buf_cnt_q  <= '0;
      tag_wr_q   <= '0;
      tag_rd_q   <= '0;
      buf_wr_q   <= '0;
      buf_rd_q   <= '0;
    end else begin
      pc_q       <= pc_d;
      out_cnt_q  <= out_cnt_d;
      disc_cnt_q <= disc_cnt_d;
      buf_cnt_q  <= buf_cnt_d;
      tag_wr_q   <= tag_wr_d;
      tag_rd_q   <= tag_rd_d;
      buf_wr_q   <= buf_wr_d;
      buf_rd_q   <= buf_rd_d;
    end
  end

  // Tag storage: record the PC of each accepted request.
  always_ff @(posedge clk_i) begin
    if (grant) begin
      tag_pc_q[tag_wr_q] <= pc_q;
    end
  end

  // Buffer storage: capture kept responses with their tag PC.
  always_ff @(posedge clk_i) begin
    if (buf_push) begin
      buf_pc_q[buf_wr_q]    <= tag_pc_q[tag_rd_q];
      buf_instr_q[buf_wr_q] <= imem_rdata_i;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  // Decode sees the registered buffer head; no bypass from imem_rdata_i.
  always_comb begin
    imem_req_o       = req;
    imem_addr_o      = pc_q;
    if_id_o.valid    = out_valid;
    if_id_o.pc       = buf_pc_q[buf_rd_q];
    if_id_o.instr    = buf_instr_q[buf_rd_q];
  end

`ifndef SYNTHESIS
  // The memory must never answer without an outstanding request.
  rvalid_without_req_a : assert property (
    @(posedge clk_i) disable iff (!rst_i)
      !(imem_rvalid_i && (out_cnt_q == '0)))
    else $error("fetch: imem_rvalid_i with no request outstanding");

  // The credit rule guarantees a kept response always has a buffer slot.
  buf_overflow_a : assert property (
    @(posedge clk_i) disable iff (!rst_i)
      buf_push |-> (buf_cnt_q < CW'(FIFO_DEPTH)) || buf_pop)
    else $error("fetch: instruction buffer overflow");

  // Only outstanding responses can be marked for discard.
  disc_bound_a : assert property (
    @(posedge clk_i) disable iff (!rst_i)
      disc_cnt_q <= out_cnt_q)
    else $error("fetch: discard count exceeds outstanding count");
`endif

endmodule
